// File: rtl/bat_amateur_pkg.sv
// Shared constants for the BatAmateur boot loader: RAM direction codes,
// loader state encoding and the segment terminator value.
package bat_amateur_pkg;

  localparam logic RAM_WRITE = 1'b0;
  localparam logic RAM_READ  = 1'b1;

  localparam int SEG_TERMINATOR = 0;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR_A   = 4'd1,
    ST_HDR_C   = 4'd2,
    ST_DATA    = 4'd3,
    ST_WRITE   = 4'd4,
    ST_VRD     = 4'd5,
    ST_VCMP    = 4'd6,
    ST_RELEASE = 4'd7,
    ST_ERR     = 4'd8
  } ld_state_e;

endpackage

// File: rtl/bat_amateur_seg_ctr.sv
// Segment pointer/word-count pair: the pointer loads from the BASE header and
// the count from the COUNT header; both advance together on each stored word.
module bat_amateur_seg_ctr #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_base,
  input  logic [AW-1:0] base,
  input  logic          load_cnt,
  input  logic [DW-1:0] count,
  input  logic          step,
  output logic [AW-1:0] ptr,
  output logic          last
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      // ptr wraps silently at the top of the address space
      if (load_base)
        ptr <= base;
      else if (step)
        ptr <= ptr + AW'(1);
      if (load_cnt)
        cnt <= count;
      else if (step)
        cnt <= cnt - DW'(1);
    end
  end

  assign last = (cnt == DW'(1));

endmodule

// File: rtl/bat_amateur_boot_loader.sv
// Boot loader for the BatAmateur CPU: holds the CPU halted, streams a segmented
// image from a valid/ready source into RAM (optionally verified), then releases the bus.
module bat_amateur_boot_loader
  import bat_amateur_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int VERIFY        = 0,
  parameter int AUTO_START    = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     SRC_VALID,
  output logic                     SRC_READY,
  input  logic [DATA_WIDTH-1:0]    SRC_DATA,
  input  logic [DATA_WIDTH-1:0]    RAM_RDATA,
  output logic                     RAM_EN,
  output logic                     RAM_RW,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
  output logic [DATA_WIDTH-1:0]    DATA_BUS,
  output logic                     BUS_OE,
  output logic                     HALT,
  output logic                     DONE,
  output logic                     ERROR,
  output logic [ADDRESS_WIDTH-1:0] ERR_ADDR
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;

  ld_state_e     state, state_d;
  logic          hs, ld_base, ld_cnt, step, latch_data, err_set, restart;
  logic [AW-1:0] ptr;
  logic          last;

  bat_amateur_seg_ctr #(.AW(AW), .DW(DW)) u_seg_ctr (
    .clk       (CLK),
    .rst_n     (RESET),
    .load_base (ld_base),
    .base      (SRC_DATA[AW-1:0]),
    .load_cnt  (ld_cnt),
    .count     (SRC_DATA),
    .step      (step),
    .ptr       (ptr),
    .last      (last)
  );

  // Next-state logic; the pointer step is folded into WRITE or VCMP
  always_comb begin
    state_d    = state;
    hs         = SRC_READY && SRC_VALID;
    ld_base    = 1'b0;
    ld_cnt     = 1'b0;
    step       = 1'b0;
    latch_data = 1'b0;
    err_set    = 1'b0;
    restart    = 1'b0;
    case (state)
      ST_IDLE:
        if (START || (AUTO_START != 0)) state_d = ST_HDR_A;
      ST_HDR_A:
        if (hs) begin
          ld_base = 1'b1;
          state_d = ST_HDR_C;
        end
      ST_HDR_C:
        if (hs) begin
          if (SRC_DATA == DW'(SEG_TERMINATOR)) begin
            state_d = ST_RELEASE;
          end else begin
            ld_cnt  = 1'b1;
            state_d = ST_DATA;
          end
        end
      ST_DATA:
        if (hs) begin
          latch_data = 1'b1;
          state_d    = ST_WRITE;
        end
      ST_WRITE:
        if (VERIFY != 0) begin
          state_d = ST_VRD;
        end else begin
          step    = 1'b1;
          state_d = last ? ST_HDR_A : ST_DATA;
        end
      ST_VRD:
        state_d = ST_VCMP;
      ST_VCMP:
        if (RAM_RDATA != DATA_BUS) begin
          err_set = 1'b1;
          state_d = ST_ERR;
        end else begin
          step    = 1'b1;
          state_d = last ? ST_HDR_A : ST_DATA;
        end
      ST_RELEASE, ST_ERR:
        if (START) begin
          restart = 1'b1;
          state_d = ST_HDR_A;
        end
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      SRC_READY   <= 1'b0;
      RAM_EN      <= 1'b0;
      RAM_RW      <= RAM_READ;
      ADDRESS_BUS <= '0;
      DATA_BUS    <= '0;
      BUS_OE      <= 1'b1;
      HALT        <= 1'b1;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
      ERR_ADDR    <= '0;
    end else begin
      state     <= state_d;
      SRC_READY <= (state_d == ST_HDR_A) || (state_d == ST_HDR_C) || (state_d == ST_DATA);
      RAM_EN    <= (state_d == ST_WRITE) || (state_d == ST_VRD);
      RAM_RW    <= (state_d == ST_WRITE) ? RAM_WRITE : RAM_READ;
      HALT      <= (state_d != ST_RELEASE);
      BUS_OE    <= (state_d != ST_RELEASE);
      DONE      <= (state_d == ST_RELEASE);
      ERROR     <= (state_d == ST_ERR);
      if ((state_d == ST_WRITE) || (state_d == ST_VRD))
        ADDRESS_BUS <= ptr;
      if (latch_data)
        DATA_BUS <= SRC_DATA;
      if (err_set)
        ERR_ADDR <= ptr;
      else if (restart)
        ERR_ADDR <= '0;
    end
  end

endmodule

// File: tb/tb_bat_amateur_boot_loader.sv
// Bench for bat_amateur_boot_loader: one plain instance and one verifying instance,
// each with a behavioural RAM, driven from image queues and checked against a segment-level model.
module tb_bat_amateur_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           start, src_valid, src_ready, ram_en, ram_rw, bus_oe, halt, done, error;
  logic [1:0][15:0]     src_data, ram_rdata, address_bus, data_bus, err_addr;

  bat_amateur_boot_loader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .VERIFY(0), .AUTO_START(1)) u_dut0 (
    .CLK(clk), .RESET(rst_n), .START(start[0]), .SRC_VALID(src_valid[0]), .SRC_READY(src_ready[0]),
    .SRC_DATA(src_data[0]), .RAM_RDATA(ram_rdata[0]), .RAM_EN(ram_en[0]), .RAM_RW(ram_rw[0]),
    .ADDRESS_BUS(address_bus[0]), .DATA_BUS(data_bus[0]), .BUS_OE(bus_oe[0]), .HALT(halt[0]),
    .DONE(done[0]), .ERROR(error[0]), .ERR_ADDR(err_addr[0]));

  bat_amateur_boot_loader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .VERIFY(1), .AUTO_START(1)) u_dut1 (
    .CLK(clk), .RESET(rst_n), .START(start[1]), .SRC_VALID(src_valid[1]), .SRC_READY(src_ready[1]),
    .SRC_DATA(src_data[1]), .RAM_RDATA(ram_rdata[1]), .RAM_EN(ram_en[1]), .RAM_RW(ram_rw[1]),
    .ADDRESS_BUS(address_bus[1]), .DATA_BUS(data_bus[1]), .BUS_OE(bus_oe[1]), .HALT(halt[1]),
    .DONE(done[1]), .ERROR(error[1]), .ERR_ADDR(err_addr[1]));

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [2][65536];
  bit          wr_flag [2][65536];
  int          nwrites [2], ren [2], stall_bad [2], hs_n [2], hs_first [2], hs_last [2];
  int          cyc = 0;
  bit          corrupt_en = 1'b0;
  int          corrupt_addr = -1;

  logic [15:0] img [$];
  logic [15:0] exp_mem [int];
  int          exp_nw, exp_hs, exp_span, exp_err_addr;
  bit          exp_err, exp_term;

  // Behavioural RAM (synchronous read, one cycle latency) plus bus/handshake monitor
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (ram_en[d]) begin
        ren[d]++;
        if (ram_rw[d] == 1'b0) begin
          mem[d][address_bus[d]] = data_bus[d];
          wr_flag[d][address_bus[d]] = 1'b1;
          nwrites[d]++;
        end else if (corrupt_en && d == 1 && int'(address_bus[d]) == corrupt_addr) begin
          ram_rdata[d] <= ~mem[d][address_bus[d]];
        end else begin
          ram_rdata[d] <= mem[d][address_bus[d]];
        end
      end
      if (src_valid[d] && src_ready[d]) begin
        if (hs_n[d] == 0) hs_first[d] = cyc;
        hs_last[d] = cyc;
        hs_n[d]++;
      end
      if (src_ready[d] && !src_valid[d] && ram_en[d]) stall_bad[d]++;
    end
  end

  // Segment-level model: walks {BASE, COUNT, data...} records, last write wins
  function automatic void run_model(input bit verify, input int bad);
    int i, base, cnt, addr;
    i = 0;
    exp_mem.delete();
    exp_nw = 0; exp_hs = 0; exp_err = 1'b0; exp_term = 1'b0; exp_err_addr = 0;
    while (!exp_err && !exp_term && i + 1 < img.size()) begin
      base = int'(img[i]);
      cnt  = int'(img[i+1]);
      i += 2;
      exp_hs += 2;
      if (cnt == 0) begin
        exp_term = 1'b1;
      end else begin
        for (int k = 0; k < cnt && !exp_err; k++) begin
          addr = (base + k) % 65536;
          exp_mem[addr] = img[i];
          i++; exp_hs++; exp_nw++;
          if (verify && addr == bad) begin
            exp_err = 1'b1;
            exp_err_addr = addr;
          end
        end
      end
    end
    exp_span = exp_hs - 1 + exp_nw * (verify ? 3 : 1);
  endfunction

  function automatic int mem_diffs(input int d);
    int n;
    n = 0;
    foreach (exp_mem[a]) if (!wr_flag[d][a] || mem[d][a] !== exp_mem[a]) n++;
    return n;
  endfunction

  task automatic gen_image(input int nseg);
    img.delete();
    for (int s = 0; s < nseg; s++) begin
      int cnt;
      logic [15:0] base;
      base = 16'($urandom);
      if ($urandom_range(0, 3) == 0) base = 16'hFFFC | 16'($urandom_range(0, 3));
      cnt = $urandom_range(1, 5);
      img.push_back(base);
      img.push_back(16'(cnt));
      for (int k = 0; k < cnt; k++) img.push_back(16'($urandom));
    end
    img.push_back(16'($urandom));
    img.push_back(16'h0000);
  endtask

  task automatic clear_logs(input int d);
    for (int a = 0; a < 65536; a++) wr_flag[d][a] = 1'b0;
    nwrites[d] = 0; ren[d] = 0; stall_bad[d] = 0;
    hs_n[d] = 0; hs_first[d] = 0; hs_last[d] = 0;
  endtask

  task automatic restart(input int d);
    if (done[d] || error[d]) begin
      @(negedge clk); start[d] = 1'b1;
      @(negedge clk); start[d] = 1'b0;
    end
  endtask

  // Offers img[first..nmax-1]; mode 0 = always valid, 1 = every other cycle, 2 = random
  task automatic drive(input int d, input int mode, input int first, input int nmax, output bit ok);
    int idx, n;
    bit rdy, v;
    idx = first; n = 0; ok = 1'b1;
    while (idx < nmax && idx < img.size()) begin
      @(negedge clk);
      if (error[d]) break;
      rdy = src_ready[d];
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (n[0] == 1'b0);
      else                v = 1'($urandom_range(0, 1));
      src_valid[d] = v;
      src_data[d]  = v ? img[idx] : 16'($urandom);
      @(posedge clk);
      if (rdy && v) idx++;
      n++;
      if (n > 4000) begin ok = 1'b0; break; end
    end
    @(negedge clk);
    src_valid[d] = 1'b0;
  endtask

  task automatic wait_end(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done[d] || error[d]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = '0; src_valid = '0; src_data = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({halt[d], bus_oe[d], ram_en[d], ram_rw[d], done[d], error[d], src_ready[d]} !== 7'b1101000) begin
        miscompares++;
        $display("FAIL reset_ctrl[%0d]: got %b want 1101000", d,
                 {halt[d], bus_oe[d], ram_en[d], ram_rw[d], done[d], error[d], src_ready[d]});
      end
      vectors++;
      if ({address_bus[d], data_bus[d], err_addr[d]} !== 48'h0) begin
        miscompares++;
        $display("FAIL reset_data[%0d]: got %h want 0", d, {address_bus[d], data_bus[d], err_addr[d]});
      end
      clear_logs(d);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (src_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL auto_start: src_ready got %b want 11", src_ready);
    end
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    img = '{16'h0010, 16'd3, 16'h0005, 16'h0000, 16'h0001,
            16'h0000, 16'd2, 16'h0010, 16'h7F98, 16'h0000, 16'h0000};
    run_model(1'b0, -1);
    clear_logs(0);
    drive(0, 0, 0, 1000, ok1);
    wait_end(0, ok2);
    vectors++;
    if (!(ok1 && ok2)) begin miscompares++; $display("FAIL basic_timeout: got %b%b want 11", ok1, ok2); end
    vectors++;
    if ({done[0], halt[0], bus_oe[0]} !== 3'b100) begin
      miscompares++; $display("FAIL basic_release: got %b want 100", {done[0], halt[0], bus_oe[0]});
    end
    vectors++;
    if ({mem[0][16'h0010], mem[0][16'h0011], mem[0][16'h0012], mem[0][16'h0000], mem[0][16'h0001]} !==
        {16'h0005, 16'h0000, 16'h0001, 16'h0010, 16'h7F98}) begin
      miscompares++;
      $display("FAIL basic_ram: got %h %h %h %h %h want 0005 0000 0001 0010 7f98", mem[0][16'h0010],
               mem[0][16'h0011], mem[0][16'h0012], mem[0][16'h0000], mem[0][16'h0001]);
    end
    vectors++;
    if (nwrites[0] !== 5) begin miscompares++; $display("FAIL basic_nwrites: got %0d want 5", nwrites[0]); end
    vectors++;
    if (hs_last[0] - hs_first[0] !== exp_span) begin
      miscompares++; $display("FAIL basic_throughput: got %0d want %0d", hs_last[0] - hs_first[0], exp_span);
    end
  endtask

  task automatic test_stall();
    bit ok1, ok2;
    clear_logs(0);
    restart(0);
    drive(0, 1, 0, 1000, ok1);
    wait_end(0, ok2);
    vectors++;
    if (!(ok1 && ok2 && done[0])) begin miscompares++; $display("FAIL stall_done: got %b want 1", done[0]); end
    vectors++;
    if (mem_diffs(0) !== 0 || nwrites[0] !== exp_nw) begin
      miscompares++; $display("FAIL stall_ram: diffs %0d writes %0d want 0 %0d", mem_diffs(0), nwrites[0], exp_nw);
    end
    vectors++;
    if (stall_bad[0] !== 0) begin miscompares++; $display("FAIL stall_ram_en: got %0d want 0", stall_bad[0]); end
    gen_image(4);
    run_model(1'b0, -1);
    clear_logs(0);
    restart(0);
    drive(0, 2, 0, 4000, ok1);
    wait_end(0, ok2);
    vectors++;
    if (!(ok1 && ok2 && done[0]) || mem_diffs(0) !== 0 || nwrites[0] !== exp_nw || stall_bad[0] !== 0) begin
      miscompares++;
      $display("FAIL stall_random: done %b diffs %0d writes %0d stall %0d want 1 0 %0d 0",
               done[0], mem_diffs(0), nwrites[0], stall_bad[0], exp_nw);
    end
  endtask

  task automatic test_wrap();
    bit ok1, ok2;
    img = '{16'hFFFE, 16'd3, 16'h000A, 16'h000B, 16'h000C, 16'h0000, 16'h0000};
    clear_logs(0);
    restart(0);
    drive(0, 0, 0, 1000, ok1);
    wait_end(0, ok2);
    vectors++;
    if ({mem[0][16'hFFFE], mem[0][16'hFFFF], mem[0][16'h0000]} !== {16'h000A, 16'h000B, 16'h000C}) begin
      miscompares++;
      $display("FAIL wrap_ram: got %h %h %h want 000a 000b 000c", mem[0][16'hFFFE], mem[0][16'hFFFF], mem[0][16'h0000]);
    end
    vectors++;
    if (!(ok1 && ok2 && done[0]) || nwrites[0] !== 3) begin
      miscompares++; $display("FAIL wrap_done: done %b writes %0d want 1 3", done[0], nwrites[0]);
    end
  endtask

  task automatic test_verify();
    bit ok1, ok2;
    img = '{16'h0010, 16'd3, 16'h0005, 16'h0000, 16'h0001,
            16'h0000, 16'd2, 16'h0010, 16'h7F98, 16'h0000, 16'h0000};
    corrupt_en = 1'b1;
    corrupt_addr = 16'h0011;
    run_model(1'b1, 16'h0011);
    clear_logs(1);
    restart(1);
    drive(1, 0, 0, 1000, ok1);
    wait_end(1, ok2);
    vectors++;
    if (!(ok1 && ok2) || {error[1], halt[1], bus_oe[1], done[1]} !== 4'b1110) begin
      miscompares++; $display("FAIL verify_err: got %b want 1110", {error[1], halt[1], bus_oe[1], done[1]});
    end
    vectors++;
    if (int'(err_addr[1]) !== exp_err_addr) begin
      miscompares++; $display("FAIL verify_err_addr: got %h want %h", err_addr[1], exp_err_addr);
    end
    vectors++;
    if (wr_flag[1][16'h0012] || nwrites[1] !== exp_nw || mem_diffs(1) !== 0) begin
      miscompares++;
      $display("FAIL verify_stop: w0012 %b writes %0d diffs %0d want 0 %0d 0", wr_flag[1][16'h0012],
               nwrites[1], mem_diffs(1), exp_nw);
    end
    corrupt_en = 1'b0;
    run_model(1'b1, -1);
    clear_logs(1);
    restart(1);
    vectors++;
    if ({error[1], halt[1], bus_oe[1], src_ready[1]} !== 4'b0111) begin
      miscompares++; $display("FAIL verify_restart: got %b want 0111", {error[1], halt[1], bus_oe[1], src_ready[1]});
    end
    drive(1, 0, 0, 1000, ok1);
    wait_end(1, ok2);
    vectors++;
    if (!(ok1 && ok2 && done[1]) || error[1] || mem_diffs(1) !== 0 || nwrites[1] !== exp_nw) begin
      miscompares++;
      $display("FAIL verify_clean: done %b err %b diffs %0d writes %0d want 1 0 0 %0d",
               done[1], error[1], mem_diffs(1), nwrites[1], exp_nw);
    end
    vectors++;
    if (hs_last[1] - hs_first[1] !== exp_span) begin
      miscompares++; $display("FAIL verify_throughput: got %0d want %0d", hs_last[1] - hs_first[1], exp_span);
    end
  endtask

  task automatic test_start_ignored();
    bit ok1, ok2;
    img = '{16'h0200, 16'd3, 16'($urandom), 16'($urandom), 16'($urandom), 16'h0000, 16'h0000};
    run_model(1'b0, -1);
    clear_logs(0);
    restart(0);
    drive(0, 0, 0, 4, ok1);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    vectors++;
    if ({src_ready[0], halt[0], done[0]} !== 3'b110) begin
      miscompares++; $display("FAIL start_in_data: got %b want 110", {src_ready[0], halt[0], done[0]});
    end
    drive(0, 0, 4, 100, ok2);
    wait_end(0, ok1);
    vectors++;
    if (!(ok1 && done[0]) || nwrites[0] !== 3 || mem_diffs(0) !== 0) begin
      miscompares++;
      $display("FAIL start_ignored: done %b writes %0d diffs %0d want 1 3 0", done[0], nwrites[0], mem_diffs(0));
    end
  endtask

  task automatic test_terminator_only();
    bit ok1;
    img = '{16'h1234, 16'h0000};
    clear_logs(0);
    restart(0);
    drive(0, 0, 0, 100, ok1);
    vectors++;
    if (!ok1 || done[0] !== 1'b1 || hs_n[0] !== 2) begin
      miscompares++; $display("FAIL term_done: done %b handshakes %0d want 1 2", done[0], hs_n[0]);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (ren[0] !== 0 || done[0] !== 1'b1) begin
      miscompares++; $display("FAIL term_no_ram: ram_en cycles %0d done %b want 0 1", ren[0], done[0]);
    end
  endtask

  task automatic test_reset_midload();
    bit ok1, ok2;
    img.delete();
    img.push_back(16'h0100);
    img.push_back(16'd15);
    for (int k = 0; k < 15; k++) img.push_back(16'($urandom));
    img.push_back(16'h0000);
    img.push_back(16'h0000);
    clear_logs(0);
    restart(0);
    drive(0, 0, 0, 5, ok1);
    @(negedge clk);
    vectors++;
    if (src_ready[0] !== 1'b1 || nwrites[0] !== 3) begin
      miscompares++; $display("FAIL midload_pre: ready %b writes %0d want 1 3", src_ready[0], nwrites[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({halt[0], bus_oe[0], ram_en[0], src_ready[0], done[0]} !== 5'b11000) begin
      miscompares++;
      $display("FAIL midload_async: got %b want 11000", {halt[0], bus_oe[0], ram_en[0], src_ready[0], done[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    gen_image(3);
    run_model(1'b0, -1);
    clear_logs(0);
    drive(0, 0, 0, 1000, ok1);
    wait_end(0, ok2);
    vectors++;
    if (!(ok1 && ok2 && done[0]) || mem_diffs(0) !== 0 || nwrites[0] !== exp_nw) begin
      miscompares++;
      $display("FAIL midload_fresh: done %b diffs %0d writes %0d want 1 0 %0d", done[0], mem_diffs(0), nwrites[0], exp_nw);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int d, mode;
    corrupt_en = 1'b0;
    for (int it = 0; it < 6; it++) begin
      d = it % 2;
      mode = (it / 2) % 3;
      gen_image(3 + it % 3);
      run_model(d == 1, -1);
      clear_logs(d);
      restart(d);
      drive(d, mode, 0, 10000, ok1);
      wait_end(d, ok2);
      vectors++;
      if (!(ok1 && ok2 && done[d]) || mem_diffs(d) !== 0 || nwrites[d] !== exp_nw || stall_bad[d] !== 0) begin
        miscompares++;
        $display("FAIL b2b[%0d] dut%0d: done %b diffs %0d writes %0d stall %0d want 1 0 %0d 0",
                 it, d, done[d], mem_diffs(d), nwrites[d], stall_bad[d], exp_nw);
      end
      if (mode == 0) begin
        vectors++;
        if (hs_last[d] - hs_first[d] !== exp_span) begin
          miscompares++;
          $display("FAIL b2b_throughput[%0d]: got %0d want %0d", it, hs_last[d] - hs_first[d], exp_span);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_verify();
    test_start_ignored();
    test_terminator_only();
    test_reset_midload();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
